maxpool_window_feeder: RTL

Sequencer on the producer side of the max-pool compare stream. It walks a square feature map held in an on-chip buffer and extracts each pooling window in row-major order. It streams the window's elements into a max-pool compare unit as `cmp_data` with a per-window `data_num`, then collects `max_pool_result` on `result_ready` and writes it to the output map buffer. It sits between the feature-map RAM and the max-pool unit in the pooling layer datapath.

---
 rtl/maxpool_window_feeder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/maxpool_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_window_feeder
// Purpose  : Walks a square feature map window by window, streams each window
//            into the max-pool compare unit and writes the results back out.
// Option   : MAXPOOL_FEEDER_TIMEOUT_EN enables the WAIT-state watchdog.
// Revision : 1.0  initial release
// ============================================================================
module maxpool_window_feeder #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int CLK_NUM_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               map_w,
    input  logic [2:0]               pool_k,
    input  logic [2:0]               pool_s,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     pool_clr,
    output logic                     cmp_valid,
    output logic [DATA_WIDTH-1:0]    cmp_data,
    output logic [CLK_NUM_WIDTH-1:0] data_num,
    input  logic                     result_ready,
    input  logic [DATA_WIDTH-1:0]    max_pool_result,
    output logic                     out_valid,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    output logic [DATA_WIDTH-1:0]    out_data
);

    localparam logic [2:0] C_MAX_POOL = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_CLEAR = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_WRITE = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               map_w_q, map_w_d;
    logic [2:0]               k_q, k_d, s_q, s_d;
    logic [7:0]               out_w_q, out_w_d;
    logic [7:0]               wr_q, wr_d, wc_q, wc_d;
    logic [2:0]               i_q, i_d, j_q, j_d;
    logic                     err_q, err_d;
    logic                     cmp_valid_q;
    logic [CLK_NUM_WIDTH-1:0] data_num_q, data_num_d;
    logic [ADDR_WIDTH-1:0]    out_idx_q, out_idx_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
`ifdef MAXPOOL_FEEDER_TIMEOUT_EN
    logic [5:0]               wd_q, wd_d;
`endif

    logic                  w_cfg_bad;
    logic [2:0]            w_div;
    logic [7:0]            w_out_w;
    logic [ADDR_WIDTH-1:0] w_row;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_result_ok;

    assign w_cfg_bad = (k_q == 3'd0) || (s_q == 3'd0) || (k_q > C_MAX_POOL) ||
                       (s_q > C_MAX_POOL) || ({5'd0, k_q} > map_w_q);
    // Divisor guarded so an illegal zero stride never reaches the divider.
    assign w_div     = (s_q == 3'd0) ? 3'd1 : s_q;
    assign w_out_w   = ((map_w_q - {5'd0, k_q}) / {5'd0, w_div}) + 8'd1;

    assign w_row     = ADDR_WIDTH'(wr_q) * ADDR_WIDTH'(s_q) + ADDR_WIDTH'(i_q);
    assign w_rd_addr = w_row * ADDR_WIDTH'(map_w_q) +
                       ADDR_WIDTH'(wc_q) * ADDR_WIDTH'(s_q) + ADDR_WIDTH'(j_q);

    // The result is only trusted once the last element has left the stream.
    assign w_result_ok = result_ready && !cmp_valid_q;

    always_comb begin
        state_d    = state_q;
        map_w_d    = map_w_q;
        k_d        = k_q;
        s_d        = s_q;
        out_w_d    = out_w_q;
        wr_d       = wr_q;
        wc_d       = wc_q;
        i_d        = i_q;
        j_d        = j_q;
        err_d      = err_q;
        data_num_d = data_num_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
`ifdef MAXPOOL_FEEDER_TIMEOUT_EN
        wd_d       = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    map_w_d    = map_w;
                    k_d        = pool_k;
                    s_d        = pool_s;
                    data_num_d = CLK_NUM_WIDTH'({5'd0, pool_k} * {5'd0, pool_k});
                    err_d      = 1'b0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    out_w_d   = w_out_w;
                    wr_d      = 8'd0;
                    wc_d      = 8'd0;
                    i_d       = 3'd0;
                    j_d       = 3'd0;
                    out_idx_d = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_ISSUE;
            S_ISSUE: begin
                if (j_q == k_q - 3'd1) begin
                    j_d = 3'd0;
                    if (i_q == k_q - 3'd1) begin
                        i_d     = 3'd0;
                        state_d = S_WAIT;
`ifdef MAXPOOL_FEEDER_TIMEOUT_EN
                        wd_d    = 6'd0;
`endif
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (w_result_ok) begin
                    out_data_d = max_pool_result;
                    state_d    = S_WRITE;
                end
`ifdef MAXPOOL_FEEDER_TIMEOUT_EN
                else if (!cmp_valid_q) begin
                    if (wd_q == 6'd63) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        wd_d = wd_q + 6'd1;
                    end
                end
`endif
            end
            S_WRITE: begin
                out_idx_d = out_idx_q + ADDR_WIDTH'(1);
                if (wc_q == out_w_q - 8'd1) begin
                    wc_d = 8'd0;
                    wr_d = wr_q + 8'd1;
                    state_d = (wr_q == out_w_q - 8'd1) ? S_FIN : S_CLEAR;
                end else begin
                    wc_d    = wc_q + 8'd1;
                    state_d = S_CLEAR;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            map_w_q     <= 8'd0;
            k_q         <= 3'd0;
            s_q         <= 3'd0;
            out_w_q     <= 8'd0;
            wr_q        <= 8'd0;
            wc_q        <= 8'd0;
            i_q         <= 3'd0;
            j_q         <= 3'd0;
            err_q       <= 1'b0;
            cmp_valid_q <= 1'b0;
            data_num_q  <= '0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
`ifdef MAXPOOL_FEEDER_TIMEOUT_EN
            wd_q        <= 6'd0;
`endif
        end else begin
            state_q     <= state_d;
            map_w_q     <= map_w_d;
            k_q         <= k_d;
            s_q         <= s_d;
            out_w_q     <= out_w_d;
            wr_q        <= wr_d;
            wc_q        <= wc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            err_q       <= err_d;
            cmp_valid_q <= (state_q == S_ISSUE);
            data_num_q  <= data_num_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
`ifdef MAXPOOL_FEEDER_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    // Windows are written in row-major order, so a running count equals wr*out_w+wc.
    assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done      = (state_q == S_FIN);
    assign err       = err_q;
    assign rd_en     = (state_q == S_ISSUE);
    assign rd_addr   = (state_q == S_ISSUE) ? w_rd_addr : '0;
    assign pool_clr  = (state_q == S_CLEAR);
    assign cmp_valid = cmp_valid_q;
    assign cmp_data  = rd_data;
    assign data_num  = data_num_q;
    assign out_valid = (state_q == S_WRITE);
    assign out_addr  = out_idx_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire
